mac_unit_vert_seq: RTL and testbench
====================================

Name: mac_unit_vert_seq

Overview:
- Self-sequenced, parametrised successor of the 16-lane vertical bit-column MAC.
- Captures one activation vector and computes its total sum internally.
- Accepts a stream of per-column weight descriptors with its own column counter, and accumulates the shifted column terms through a 2-stage pipeline.
- Presents the final dot-product result on a valid/ready handshake.
- Sits between the weight-column scheduler and the output-channel accumulator buffer.

Parameters:
- DATA_WIDTH, 8: activation width, signed.
- VEC_LENGTH, 16: activations per vector; power of 2, ≥4.
- SEL_COUNT, VEC_LENGTH/2: number of activation-select muxes/adder inputs; power of 2.
- WEIGHT_BITS, 8: maximum columns per vector; column index range 0..WEIGHT_BITS-1.
- SEL_WIDTH, $clog2(VEC_LENGTH)+1: select width; value ≥VEC_LENGTH selects zero.
- SUM_ACT_WIDTH, DATA_WIDTH+$clog2(VEC_LENGTH): width of the internal vector sum.
- RESULT_WIDTH, SUM_ACT_WIDTH+WEIGHT_BITS+5: accumulator/result width.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (asserted when 0).
- act_valid, input, 1: activation vector offered.
- act_ready, output, 1: block can capture a vector.
- act, input, DATA_WIDTH×VEC_LENGTH: signed activation vector.
- col_valid, input, 1: column descriptor offered.
- col_ready, output, 1: block accepts a descriptor.
- act_sel, input, SEL_WIDTH×SEL_COUNT: per-mux activation select.
- is_msb, input, 1: negate this column's term.
- is_skip_zero, input, 1: 1 = term is the sum of selected acts; 0 = term is sum_act minus the selected sum.
- special_en, input, 1: add the special (multiplier + hamming) term.
- mul_const, input, 3: unsigned multiplier applied to sum_act.
- is_shift_mul, input, 1: shift the multiplier product left by 3.
- hamming_sel, input, SEL_WIDTH: select for the hamming activation.
- hamming_sign, input, 1: negate the hamming activation.
- col_last, input, 1: final column for this vector.
- res_valid, output, 1: result available.
- res_ready, input, 1: consumer accepts the result.
- result, output, RESULT_WIDTH: signed accumulated result.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset (async on the falling edge of reset):
  - state=IDLE; act_ready=1; col_ready=0; res_valid=0; busy=0.
  - result, accumulator, col_idx, pipeline valid bits and all data registers = 0.
  - Reset mid-operation discards everything; no partial result is ever emitted.
- FSM IDLE → ACCUM:
  - act_ready=1 in IDLE only.
  - On act_valid&act_ready: register act, and register sum_act = signed sum of all VEC_LENGTH acts (SUM_ACT_WIDTH bits, exact).
  - col_idx=0, accumulator=0.
- FSM ACCUM:
  - col_ready=1 while no last column is in flight.
  - Each col_valid&col_ready handshake loads stage 1 (edge k) with the following, computed from registered act/sum_act:
    - muxed selected acts, their signed sum P;
    - mode bits, the hamming act and the current col_idx.
  - Then col_idx++.
  - A column is last if col_last=1 or col_idx==WEIGHT_BITS-1 (forced last; later descriptors are not accepted).
  - Accepting the last column → DRAIN; col_ready drops in the following cycle.
- Stage 2 (edge k+1), column term T:
  - T = {is_msb,is_skip_zero}: 00 → sum_act−P; 01 → P; 10 → P−sum_act; 11 → −P.
  - T is shifted left by col_idx.
  - If special_en: add (sum_act×mul_const, then <<3 if is_shift_mul) + ((hamming_sign ? −H : H) << col_idx).
  - All operands are sign-extended to RESULT_WIDTH; the accumulator adds the result and wraps modulo 2^RESULT_WIDTH.
- FSM DRAIN → DONE: once stage 2 has retired the last column (edge k+1), result := accumulator and res_valid=1.
  - res_valid therefore appears 2 edges after the last-column handshake.
  - Back-to-back columns run one per cycle with no bubbles.
- FSM DONE:
  - res_valid and result are held stable while res_ready=0.
  - On res_valid&res_ready: → IDLE; res_valid=0; result keeps its value until the next DONE.
  - act_ready rises in the cycle after the result handshake (no same-cycle overlap).
- Select rule: any select value ≥VEC_LENGTH contributes 0. The same vector element may be selected by multiple muxes.
- Inputs are ignored when their handshake is not active: col_* in IDLE/DRAIN/DONE, and act in any state other than IDLE.

Test Plan:
- All acts=1 (sum_act=16). Col0 sel 0..7, is_skip_zero=1; col1 same sel, is_skip_zero=0, col_last. → result=8+(8<<1)=24; res_valid 2 edges after the col1 handshake.
- All acts=2. Single column, is_msb=1, is_skip_zero=1, sel 0..7, col_last → result=−16. Also sels all =VEC_LENGTH → result=0.
- acts all 1, act[5]=−4 (sum_act=11). Col0 sel all =16, is_skip_zero=1, special_en=1, mul_const=3, is_shift_mul=1, hamming_sel=5, hamming_sign=1, col_last → result=264+4=268.
- Stream WEIGHT_BITS=8 columns with col_last never set, each term P=1 → the 8th column is forced last, col_ready drops, result=255; a 9th offered descriptor is not accepted.
- Hold res_ready=0 for 5 cycles → result/res_valid stable, act_ready=0. Then pulse res_ready → IDLE, next vector accepted.
- Assert reset after 3 columns accepted → all outputs return to reset values immediately. A new vector with a single P=5 column yields 5, with no residue from the aborted run.

Source files
------------

// File: rtl/mac_unit_vert_seq.sv
// Vertical bit-column MAC: one activation vector times a stream of weight-column descriptors.
// Latency: the last column handshake is followed by res_valid 2 clock edges later; columns run one per cycle.
// Backpressure: act_ready only in IDLE, col_ready only in ACCUM; the result is held until res_ready.
module mac_unit_vert_seq #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 16,
  parameter int SEL_COUNT     = VEC_LENGTH / 2,
  parameter int WEIGHT_BITS   = 8,
  parameter int SEL_WIDTH     = $clog2(VEC_LENGTH) + 1,
  parameter int SUM_ACT_WIDTH = DATA_WIDTH + $clog2(VEC_LENGTH),
  parameter int RESULT_WIDTH  = SUM_ACT_WIDTH + WEIGHT_BITS + 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 act_valid,
  output logic                                 act_ready,
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0]     act,
  input  logic                                 col_valid,
  output logic                                 col_ready,
  input  logic [SEL_WIDTH*SEL_COUNT-1:0]       act_sel,
  input  logic                                 is_msb,
  input  logic                                 is_skip_zero,
  input  logic                                 special_en,
  input  logic [2:0]                           mul_const,
  input  logic                                 is_shift_mul,
  input  logic [SEL_WIDTH-1:0]                 hamming_sel,
  input  logic                                 hamming_sign,
  input  logic                                 col_last,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic signed [RESULT_WIDTH-1:0]       result,
  output logic                                 busy
);
  localparam int CIDX_W = (WEIGHT_BITS > 1) ? $clog2(WEIGHT_BITS) : 1;
  localparam int IDX_W  = $clog2(VEC_LENGTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                               state_q, state_d;
  logic [DATA_WIDTH*VEC_LENGTH-1:0]     act_q, act_d;
  logic signed [SUM_ACT_WIDTH-1:0]      sum_act_q, sum_act_d;
  logic [CIDX_W-1:0]                    col_idx_q, col_idx_d;
  logic signed [RESULT_WIDTH-1:0]       acc_q, acc_d;
  logic signed [RESULT_WIDTH-1:0]       result_q, result_d;
  logic                                 s2_last_q, s2_last_d;
  // Stage 1 column registers
  logic                                 s1_vld_q, s1_vld_d;
  logic signed [SUM_ACT_WIDTH-1:0]      s1_p_q, s1_p_d;
  logic                                 s1_msb_q, s1_msb_d;
  logic                                 s1_skip_q, s1_skip_d;
  logic                                 s1_spec_q, s1_spec_d;
  logic [2:0]                           s1_mul_q, s1_mul_d;
  logic                                 s1_shm_q, s1_shm_d;
  logic signed [DATA_WIDTH-1:0]         s1_ham_q, s1_ham_d;
  logic                                 s1_hsgn_q, s1_hsgn_d;
  logic [CIDX_W-1:0]                    s1_idx_q, s1_idx_d;
  logic                                 s1_last_q, s1_last_d;

  // Selects at or beyond VEC_LENGTH have the MSB set and contribute zero.
  function automatic logic signed [DATA_WIDTH-1:0] pick(input logic [DATA_WIDTH*VEC_LENGTH-1:0] v,
                                                        input logic [SEL_WIDTH-1:0] s);
    if (s[SEL_WIDTH-1]) return '0;
    return v[int'(s[IDX_W-1:0])*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Exact sum of the incoming vector and of the selected registered activations.
  logic signed [SUM_ACT_WIDTH-1:0] sum_in, p_sum;
  always_comb begin
    sum_in = '0;
    for (int i = 0; i < VEC_LENGTH; i++)
      sum_in = sum_in + SUM_ACT_WIDTH'(signed'(act[i*DATA_WIDTH +: DATA_WIDTH]));
    p_sum = '0;
    for (int j = 0; j < SEL_COUNT; j++)
      p_sum = p_sum + SUM_ACT_WIDTH'(pick(act_q, act_sel[j*SEL_WIDTH +: SEL_WIDTH]));
  end

  // Stage 2 column term, all operands sign-extended to the accumulator width.
  logic signed [RESULT_WIDTH-1:0] sum_ext, p_ext, t_base, mul_ext, mul_term, ham_ext, ham_term, term;
  always_comb begin
    sum_ext = RESULT_WIDTH'(sum_act_q);
    p_ext   = RESULT_WIDTH'(s1_p_q);
    case ({s1_msb_q, s1_skip_q})
      2'b00:   t_base = sum_ext - p_ext;
      2'b01:   t_base = p_ext;
      2'b10:   t_base = p_ext - sum_ext;
      default: t_base = -p_ext;
    endcase
    mul_ext  = RESULT_WIDTH'(signed'({1'b0, s1_mul_q}));
    mul_term = sum_ext * mul_ext;
    if (s1_shm_q) mul_term = mul_term <<< 3;
    ham_ext  = RESULT_WIDTH'(s1_ham_q);
    ham_term = (s1_hsgn_q ? -ham_ext : ham_ext) <<< s1_idx_q;
    term     = t_base <<< s1_idx_q;
    if (s1_spec_q) term = term + mul_term + ham_term;
  end

  // Next-state logic: FSM, stage-1 capture and stage-2 accumulation.
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    sum_act_d = sum_act_q;
    col_idx_d = col_idx_q;
    acc_d     = acc_q;
    result_d  = result_q;
    s2_last_d = 1'b0;
    s1_vld_d  = 1'b0;
    s1_p_d    = s1_p_q;
    s1_msb_d  = s1_msb_q;
    s1_skip_d = s1_skip_q;
    s1_spec_d = s1_spec_q;
    s1_mul_d  = s1_mul_q;
    s1_shm_d  = s1_shm_q;
    s1_ham_d  = s1_ham_q;
    s1_hsgn_d = s1_hsgn_q;
    s1_idx_d  = s1_idx_q;
    s1_last_d = s1_last_q;

    if (s1_vld_q) begin
      acc_d     = acc_q + term;
      s2_last_d = s1_last_q;
    end

    case (state_q)
      IDLE: if (act_valid) begin
        act_d     = act;
        sum_act_d = sum_in;
        col_idx_d = '0;
        acc_d     = '0;
        state_d   = ACCUM;
      end
      ACCUM: if (col_valid) begin
        s1_vld_d  = 1'b1;
        s1_p_d    = p_sum;
        s1_msb_d  = is_msb;
        s1_skip_d = is_skip_zero;
        s1_spec_d = special_en;
        s1_mul_d  = mul_const;
        s1_shm_d  = is_shift_mul;
        s1_ham_d  = pick(act_q, hamming_sel);
        s1_hsgn_d = hamming_sign;
        s1_idx_d  = col_idx_q;
        s1_last_d = col_last || (col_idx_q == CIDX_W'(WEIGHT_BITS - 1));
        col_idx_d = col_idx_q + CIDX_W'(1);
        if (s1_last_d) state_d = DRAIN;
      end
      DRAIN: if (s2_last_q) begin
        result_d = acc_q;
        state_d  = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; asynchronous reset discards any run in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      act_q     <= '0;
      sum_act_q <= '0;
      col_idx_q <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      s2_last_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_p_q    <= '0;
      s1_msb_q  <= 1'b0;
      s1_skip_q <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_mul_q  <= '0;
      s1_shm_q  <= 1'b0;
      s1_ham_q  <= '0;
      s1_hsgn_q <= 1'b0;
      s1_idx_q  <= '0;
      s1_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      sum_act_q <= sum_act_d;
      col_idx_q <= col_idx_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      s2_last_q <= s2_last_d;
      s1_vld_q  <= s1_vld_d;
      s1_p_q    <= s1_p_d;
      s1_msb_q  <= s1_msb_d;
      s1_skip_q <= s1_skip_d;
      s1_spec_q <= s1_spec_d;
      s1_mul_q  <= s1_mul_d;
      s1_shm_q  <= s1_shm_d;
      s1_ham_q  <= s1_ham_d;
      s1_hsgn_q <= s1_hsgn_d;
      s1_idx_q  <= s1_idx_d;
      s1_last_q <= s1_last_d;
    end
  end

  assign act_ready = (state_q == IDLE);
  assign col_ready = (state_q == ACCUM);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// Directed bench for mac_unit_vert_seq with hand-computed results.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Waits for res_valid are bounded and report a timeout as a failed check.
module tb_mac_unit_vert_seq;
  localparam int DW = 8, VL = 16, SC = 8, SW = 5, RW = 25;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            act_valid = 1'b0, col_valid = 1'b0, res_ready = 1'b0;
  logic [DW*VL-1:0] act = '0;
  logic [SW*SC-1:0] act_sel = '0;
  logic            is_msb = 1'b0, is_skip_zero = 1'b0, special_en = 1'b0;
  logic [2:0]      mul_const = '0;
  logic            is_shift_mul = 1'b0, hamming_sign = 1'b0, col_last = 1'b0;
  logic [SW-1:0]   hamming_sel = '0;
  logic            act_ready, col_ready, res_valid, busy;
  logic signed [RW-1:0] result;

  int errors = 0;
  int checks = 0;

  mac_unit_vert_seq dut (
    .clk(clk), .reset(reset),
    .act_valid(act_valid), .act_ready(act_ready), .act(act),
    .col_valid(col_valid), .col_ready(col_ready), .act_sel(act_sel),
    .is_msb(is_msb), .is_skip_zero(is_skip_zero), .special_en(special_en),
    .mul_const(mul_const), .is_shift_mul(is_shift_mul),
    .hamming_sel(hamming_sel), .hamming_sign(hamming_sign), .col_last(col_last),
    .res_valid(res_valid), .res_ready(res_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW*VL-1:0] mk_act(input int val);
    logic [DW*VL-1:0] v;
    for (int i = 0; i < VL; i++) v[i*DW +: DW] = DW'(val);
    return v;
  endfunction

  // Mux i selects element i for i < n, otherwise the out-of-range value VL.
  function automatic logic [SW*SC-1:0] mk_sel(input int n);
    logic [SW*SC-1:0] s;
    for (int i = 0; i < SC; i++) s[i*SW +: SW] = (i < n) ? SW'(i) : SW'(VL);
    return s;
  endfunction

  // All driving tasks start and end on a falling edge.
  task automatic send_act(input string tag, input logic [DW*VL-1:0] v);
    act = v; act_valid = 1'b1;
    check({tag, "_act_ready"}, act_ready, 1);
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  task automatic send_col(input string tag, input logic [SW*SC-1:0] sel, input logic msb,
                          input logic skip, input logic spec, input logic [2:0] mul,
                          input logic shm, input logic [SW-1:0] hsel, input logic hsgn,
                          input logic last);
    act_sel = sel; is_msb = msb; is_skip_zero = skip; special_en = spec;
    mul_const = mul; is_shift_mul = shm; hamming_sel = hsel; hamming_sign = hsgn;
    col_last = last; col_valid = 1'b1;
    check({tag, "_col_ready"}, col_ready, 1);
    @(negedge clk);
    col_valid = 1'b0;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("ack_act_ready", act_ready, 1);
    check("ack_res_valid", res_valid, 0);
  endtask

  task automatic wait_res(input string tag, input longint exp);
    int n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, (n < 20) ? 1 : 0, 1);
    check(tag, result, exp);
  endtask

  initial begin
    logic [DW*VL-1:0] v;
    repeat (2) @(negedge clk);
    check("rst_act_ready", act_ready, 1);
    check("rst_col_ready", col_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    reset = 1'b1;
    @(negedge clk);

    // Two columns of ones: 8 + (16-8)<<1 = 24, with latency checked edge by edge.
    send_act("t1", mk_act(1));
    check("t1_busy", busy, 1);
    send_col("t1c0", mk_sel(8), 0, 1, 0, 0, 0, 0, 0, 0);
    send_col("t1c1", mk_sel(8), 0, 0, 0, 0, 0, 0, 0, 1);
    check("t1_col_ready_drop", col_ready, 0);
    check("t1_res_valid_e1", res_valid, 0);
    @(negedge clk);
    check("t1_res_valid_e2", res_valid, 0);
    @(negedge clk);
    check("t1_res_valid_e3", res_valid, 1);
    check("t1_result", result, 24);
    ack();

    // Negated selected sum, then all selects out of range.
    send_act("t2a", mk_act(2));
    send_col("t2a", mk_sel(8), 1, 1, 0, 0, 0, 0, 0, 1);
    wait_res("t2a_result", -16);
    ack();
    send_act("t2b", mk_act(2));
    send_col("t2b", mk_sel(0), 1, 1, 0, 0, 0, 0, 0, 1);
    wait_res("t2b_result", 0);
    ack();

    // Special term: sum_act=11, 11*3<<3 = 264, -(-4) = 4.
    v = mk_act(1);
    v[5*DW +: DW] = 8'hFC;
    send_act("t3", v);
    send_col("t3", mk_sel(0), 0, 1, 1, 3'd3, 1, 5'd5, 1, 1);
    wait_res("t3_result", 268);
    ack();

    // Eight columns without col_last: the eighth is forced last, a ninth is refused.
    send_act("t4", mk_act(1));
    for (int k = 0; k < 8; k++) send_col("t4", mk_sel(1), 0, 1, 0, 0, 0, 0, 0, 0);
    check("t4_col_ready_drop", col_ready, 0);
    act_sel = mk_sel(1); is_skip_zero = 1'b1; col_last = 1'b0; col_valid = 1'b1;
    wait_res("t4_result", 255);
    col_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_result", result, 255);
      check("t4_hold_act_ready", act_ready, 0);
    end
    ack();
    check("t4_busy_idle", busy, 0);

    // Reset after three accepted columns, then a clean run.
    send_act("t6", mk_act(1));
    for (int k = 0; k < 3; k++) send_col("t6", mk_sel(1), 0, 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check("t6_rst_act_ready", act_ready, 1);
    check("t6_rst_col_ready", col_ready, 0);
    check("t6_rst_res_valid", res_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_act("t6b", mk_act(1));
    send_col("t6b", mk_sel(5), 0, 1, 0, 0, 0, 0, 0, 1);
    wait_res("t6b_result", 5);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
